// File: rtl/rf_alu_pkg.sv
// Shared widths, ALU opcodes and sequencer types for the register-file/ALU datapath.
package rf_alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned CNT_W  = 6;

    localparam logic [OP_W-1:0] ALU_NOP = 5'h00;
    localparam logic [OP_W-1:0] ALU_ADD = 5'h01;
    localparam logic [OP_W-1:0] ALU_SUB = 5'h02;
    localparam logic [OP_W-1:0] ALU_AND = 5'h03;
    localparam logic [OP_W-1:0] ALU_OR  = 5'h04;
    localparam logic [OP_W-1:0] ALU_XOR = 5'h05;
    localparam logic [OP_W-1:0] ALU_SLL = 5'h06;
    localparam logic [OP_W-1:0] ALU_SRL = 5'h07;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_e;

    // Shared control for the three lock-step address registers.
    typedef enum logic [1:0] {
        AgHold,
        AgLoad,
        AgInc
    } ag_ctrl_e;

endpackage

// File: rtl/rf_addr_gen.sv
// Three wrapping register-file address registers sharing one load/increment/hold control.
module rf_addr_gen
    import rf_alu_pkg::*;
#(
    parameter int unsigned ADDR_W = rf_alu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  ag_ctrl_e          ctrl,
    input  logic [ADDR_W-1:0] src1_base,
    input  logic [ADDR_W-1:0] src2_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] r1_addr,
    output logic [ADDR_W-1:0] r2_addr,
    output logic [ADDR_W-1:0] w_addr
);

    logic [ADDR_W-1:0] r1_q, r1_d;
    logic [ADDR_W-1:0] r2_q, r2_d;
    logic [ADDR_W-1:0] w_q, w_d;

    // Increments rely on natural ADDR_W-bit wrap (31 -> 0 for 32 registers).
    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        w_d  = w_q;
        unique case (ctrl)
            AgLoad: begin
                r1_d = src1_base;
                r2_d = src2_base;
                w_d  = dst_base;
            end
            AgInc: begin
                r1_d = r1_q + ADDR_W'(1);
                r2_d = r2_q + ADDR_W'(1);
                w_d  = w_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q <= '0;
            r2_q <= '0;
            w_q  <= '0;
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
            w_q  <= w_d;
        end
    end

    assign r1_addr = r1_q;
    assign r2_addr = r2_q;
    assign w_addr  = w_q;

endmodule

// File: rtl/rf_alu_seq.sv
// Command-driven vector sequencer: one element per cycle over the register file and ALU,
// with pause, a one-cycle done pulse and a remaining-element count.
module rf_alu_seq
    import rf_alu_pkg::*;
#(
    parameter int unsigned ADDR_W = rf_alu_pkg::ADDR_W,
    parameter int unsigned OP_W   = rf_alu_pkg::OP_W,
    parameter int unsigned CNT_W  = rf_alu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              pause,
    output logic [ADDR_W-1:0] rf_r1_addr,
    output logic [ADDR_W-1:0] rf_r2_addr,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic              rf_w_en,
    output logic [OP_W-1:0]   alu_op,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  remaining
);

    seq_state_e       state_q;
    logic [OP_W-1:0]  op_q;
    logic [CNT_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;
    logic             advance;
    ag_ctrl_e         ag_ctrl;

    // Gating with rst keeps both the handshake and the write port quiet during reset.
    assign cmd_ready = (state_q == StIdle) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign advance   = (state_q == StRun) && !pause;
    assign rf_w_en   = advance && !rst;

    always_comb begin
        ag_ctrl = AgHold;
        if (accept) begin
            ag_ctrl = AgLoad;
        end else if (advance) begin
            ag_ctrl = AgInc;
        end
    end

    rf_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ag_ctrl),
        .src1_base (cmd_src1),
        .src2_base (cmd_src2),
        .dst_base  (cmd_dst),
        .r1_addr   (rf_r1_addr),
        .r2_addr   (rf_r2_addr),
        .w_addr    (rf_w_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        rem_q  <= cmd_count;
                        busy_q <= 1'b1;
                        if (cmd_count != '0) begin
                            state_q <= StRun;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (!pause) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_op    = op_q;
    assign remaining = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/rf_alu_seq.md
# rf_alu_seq

Command-driven sequencer that runs vector operations on the register-file/ALU datapath. It accepts one command (op, two source bases, destination base, element count). It then drives the register-file read/write addresses, write enable and ALU opcode for one element per cycle, with all three addresses advancing in lock-step. It replaces the free-running address counters in the top level so software-style commands, such as a Fibonacci chain or a vector add, can be launched, paused and observed for completion.

## Interface
Parameters:
- DATA_W, 32, datapath width (carried for the package; the block itself handles no data)
- ADDR_W, 5, register-file address width; 32 registers
- OP_W, 5, ALU opcode width
- CNT_W, 6, element-count width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  OP_W  ALU opcode for the whole command
- cmd_src1  in  ADDR_W  base address for read port 1
- cmd_src2  in  ADDR_W  base address for read port 2
- cmd_dst  in  ADDR_W  base address for the write port
- cmd_count  in  CNT_W  number of elements, 0..63
- pause  in  1  stall request; honoured only in RUN
- rf_r1_addr  out  ADDR_W  register-file read address 1
- rf_r2_addr  out  ADDR_W  register-file read address 2
- rf_w_addr  out  ADDR_W  register-file write address
- rf_w_en  out  1  register-file write enable
- alu_op  out  OP_W  ALU opcode
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- remaining  out  CNT_W  elements still to be written

## Operation
- FSM states: IDLE, RUN and DONE.
- IDLE:
  - cmd_ready=1.
  - A handshake occurs on a rising edge with cmd_valid&&cmd_ready.
  - At that edge, the block latches op/src1/src2/dst/count into the address, opcode and remaining registers.
  - Next state is RUN if count!=0, otherwise DONE.
- RUN:
  - rf_w_en = !pause (combinational).
  - Addresses and alu_op come directly from the registers.
  - Each edge with !pause:
    - the element is written by the register file;
    - all three addresses increment modulo 2^ADDR_W (31 wraps to 0);
    - remaining decrements.
  - When remaining==1 and !pause, next state is DONE.
  - While pause is high, all registers hold and no write occurs.
- DONE:
  - done=1 for exactly one cycle, then the FSM returns to IDLE.
  - Addresses hold their final post-increment values.
- cmd_valid outside IDLE is ignored, since cmd_ready=0; no command queueing.
- Register file reads are asynchronous and writes are synchronous. An element written at edge k is visible to the read at cycle k+1, so chained commands (dst = src2+1 = src1+2) produce recurrences correctly.
- Overlapping or identical src/dst ranges are legal; no hazard checking.
- pause outside RUN has no effect.
- rst in any state:
  - state returns to IDLE;
  - all address registers, alu_op and remaining go to 0;
  - no write occurs in the reset cycle (rf_w_en=0 while rst=1).
  - An aborted command is not resumed and done does not pulse.

## Timing
- Reset values: cmd_ready=0 while rst=1 and 1 in the cycle after; busy=0, done=0, rf_w_en=0, all addresses 0, alu_op=0, remaining=0.
- Accept edge to first write cycle: 1 cycle.
- Unpaused command of N≥1 elements: N RUN cycles, then 1 DONE cycle. cmd_ready returns N+2 cycles after the accept edge.
- count=0: DONE occupies the cycle after acceptance with zero writes. cmd_ready returns 2 cycles after the accept edge.
- Each paused cycle adds exactly one cycle of latency.
- done and cmd_ready are never high in the same cycle.

## Structure
- Shared package rf_alu_pkg, holding:
  - width constants (DATA_W, ADDR_W, OP_W, CNT_W);
  - ALU opcode constants, with ALU_ADD=5'h01 matching the current top level;
  - the sequencer state enum.
- One sub-module is natural: rf_addr_gen, holding the three wrapping address registers with a shared load/increment/hold control.
- The FSM and remaining counter stay in rf_alu_seq.
- The top level instantiates rf_alu_seq between the command source and the existing ALU/register-file pair.

## Test plan
- Fibonacci:
  - Stimulus: preload r0=1, r1=1; issue cmd op=5'h01, src1=0, src2=1, dst=2, count=8.
  - Response: r2..r9 = 2,3,5,8,13,21,34,55; done pulses 9 cycles after the accept edge; exactly 8 rf_w_en cycles.
- Zero count:
  - Stimulus: issue count=0.
  - Response: no rf_w_en; done the cycle after accept; cmd_ready high the following cycle.
- Wrap-around:
  - Stimulus: src1=30, src2=31, dst=31, count=3.
  - Response: rf_w_addr sequence 31,0,1; rf_r1_addr sequence 30,31,0.
- Pause:
  - Stimulus: count=4 with pause high for 2 cycles during element 2.
  - Response: rf_w_en low and addresses/remaining frozen for those 2 cycles; done 7 cycles after accept; register contents identical to the unpaused run.
- Busy rejection:
  - Stimulus: hold cmd_valid high with a second command during RUN.
  - Response: cmd_ready=0; the second command is accepted only in the cycle after done.
- Reset mid-run:
  - Stimulus: assert rst for 1 cycle after 2 of 6 writes.
  - Response: no further writes; no done pulse; all outputs at reset values the next cycle; cmd_ready=1 one cycle later.
